mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one Mux8Bits-style 8:1 32-bit datapath mux among 8 requesters.
//  - Decides which requester owns the mux and drives the mux's 3-bit selector.
//  - Returns a one-hot grant to the owner.
//  - A long-holding owner can be preempted after a bounded number of cycles.
//  - Sits between the requesting units (control FSM, DMA-like agents) and the mux's selector input.
// PARAMETERS
//  MAX_HOLD  16  cycles an owner keeps the mux while others wait; 0 = unlimited (no preemption)
//  CNT_W     5   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-low reset (0 = reset)
//  req          in   8  req[i]=1: requester i wants the mux; held high for the whole use
//  grant        out  8  one-hot owner; all-zero when no owner
//  selector     out  3  binary index of owner; drives Mux8Bits selector
//  grant_valid  out  1  1 while an owner exists (== |grant)
//  preempt      out  1  1-cycle pulse on the edge where ownership is taken by hold timeout
// BEHAVIOUR
//  Reset values (async, immediate on reset=0, also mid-transfer):
//   grant=0, selector=0, grant_valid=0, preempt=0, state=IDLE, hold_cnt=0, last_ptr=7.
//  All outputs are registered; nothing is combinational from req.
//  Priority search from last_ptr+1 mod 8 upward (wrap 7->0); first set req bit wins = pick.
//  States:
//   IDLE  : if |req at edge -> GRANT, owner=pick, last_ptr=pick, hold_cnt=0.
//           Latency: req high in cycle n -> grant visible in cycle n+1.
//   GRANT : each edge evaluates, in this priority order:
//    1 req[owner]=0 (release):
//      - other req pending -> owner=pick (no idle bubble), last_ptr=pick, hold_cnt=0.
//      - else -> IDLE, grant=0, grant_valid=0.
//    2 MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another req pending:
//      - owner=pick (excluding current owner), hold_cnt=0, preempt=1 for one cycle.
//    3 else stay; hold_cnt+=1, saturating at MAX_HOLD-1 (no wrap); no other req -> owner keeps mux.
//  selector:
//   - updated on the same edge as grant; always equals index of the set grant bit.
//   - in IDLE it holds its last value (datapath sees a stable input; consumers qualify with grant_valid).
//  Preempted requester keeps req high: it re-enters the round-robin and is served again after the others.
//  A req bit that drops before being granted has no effect; no latching of requests.
//  X/Z on req is not tolerated; bench drives known values only.
// TESTING
//  T1 reset=0 mid-GRANT (owner 3) -> same cycle grant=0, selector=0, grant_valid=0; after release, req=8'h01 -> grant=8'h01 next cycle.
//  T2 after reset, req=8'hFF, each owner drops req 1 cycle after grant -> owner order 0,1,2,...,7,0; selector matches; no idle cycles.
//  T3 MAX_HOLD=4: req[2] high continuously, then req[5] raised -> owner 2 gets 4 cycles total (hold_cnt 0..3 when 5 waits), then grant=8'h20, preempt pulses 1 cycle.
//  T4 MAX_HOLD=4, only req[6] high for 20 cycles -> grant=8'h40 throughout, preempt never asserted, hold_cnt saturates at 3.
//  T5 owner 7 releases while req[0] and req[6] pending -> next owner 0 (wrap), then 6.
//  T6 MAX_HOLD=0: req[1] held 100 cycles with req[4] pending -> no preemption; grant moves to 4 one cycle after req[1] drops.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the selector of a shared 8:1 32-bit datapath mux.
// Registered one-hot grant/selector with optional hold-timeout preemption of a long owner.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] selector,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Ceiling of the hold counter; with preemption disabled it just parks at all-ones.
  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [2:0]       last_ptr, last_nxt;
  logic [2:0]       sel_nxt;
  logic [7:0]       grant_nxt;
  logic             pre_nxt;

  logic [7:0]       others;
  logic             pick_found;
  logic [2:0]       pick;

  // Search from last_ptr+1 upward; iterating the offsets downward lets the nearest hit win.
  // The current owner is masked out, so the pick is always "someone else" while granted.
  always_comb begin
    others     = req & ~grant;
    pick_found = 1'b0;
    pick       = last_ptr;
    for (int k = 8; k >= 1; k--) begin
      if (others[last_ptr + 3'(k)]) begin
        pick_found = 1'b1;
        pick       = last_ptr + 3'(k);
      end
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = selector;
    hold_nxt  = hold_cnt;
    last_nxt  = last_ptr;
    pre_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          grant_nxt = 8'h01 << pick;
          sel_nxt   = pick;
          last_nxt  = pick;
          hold_nxt  = '0;
        end
      end

      GRANT: begin
        if (!req[selector]) begin
          if (pick_found) begin
            grant_nxt = 8'h01 << pick;
            sel_nxt   = pick;
            last_nxt  = pick;
            hold_nxt  = '0;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && pick_found) begin
          grant_nxt = 8'h01 << pick;
          sel_nxt   = pick;
          last_nxt  = pick;
          hold_nxt  = '0;
          pre_nxt   = 1'b1;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= '0;
      selector    <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      hold_cnt    <= '0;
      last_ptr    <= 3'd7;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      selector    <= sel_nxt;
      grant_valid <= |grant_nxt;
      preempt     <= pre_nxt;
      hold_cnt    <= hold_nxt;
      last_ptr    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: three instances (MAX_HOLD 16, 4, 0) checked against a
// cycle model through an expected-value queue, plus directed scenario checks.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r [3];
  logic [7:0] g [3];
  logic [2:0] s [3];
  logic       v [3];
  logic       p [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) u0 (
    .clk(clk), .reset(reset), .req(r[0]), .grant(g[0]), .selector(s[0]),
    .grant_valid(v[0]), .preempt(p[0]));
  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(3)) u4 (
    .clk(clk), .reset(reset), .req(r[1]), .grant(g[1]), .selector(s[1]),
    .grant_valid(v[1]), .preempt(p[1]));
  mux8_rr_arbiter #(.MAX_HOLD(0), .CNT_W(5)) uz (
    .clk(clk), .reset(reset), .req(r[2]), .grant(g[2]), .selector(s[2]),
    .grant_valid(v[2]), .preempt(p[2]));

  typedef struct {
    logic       v;
    logic [2:0] own;
    logic [2:0] last;
    int         hold;
    logic       pre;
  } mdl_t;

  typedef struct {
    int         inst;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    logic       p;
    int         hold;
  } exp_t;

  mdl_t m [3];
  int   mh [3] = '{16, 4, 0};
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [7:0] rq, input logic [2:0] from);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (int'(from) + k) % 8;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].v    = 1'b0;
      m[i].own  = 3'd0;
      m[i].last = 3'd7;
      m[i].hold = 0;
      m[i].pre  = 1'b0;
    end
  endtask

  task automatic model_take(input int i, input int pk);
    m[i].own  = 3'(pk);
    m[i].last = 3'(pk);
    m[i].hold = 0;
    m[i].v    = 1'b1;
  endtask

  task automatic model_step(input int i);
    logic [7:0] rq;
    int         pk;
    rq       = r[i];
    m[i].pre = 1'b0;
    if (!m[i].v) begin
      pk = rr_pick(rq, m[i].last);
      if (pk >= 0) model_take(i, pk);
    end else begin
      pk = rr_pick(rq & ~(8'h01 << m[i].own), m[i].last);
      if (!rq[m[i].own]) begin
        if (pk >= 0) model_take(i, pk);
        else m[i].v = 1'b0;
      end else if (mh[i] != 0 && m[i].hold == mh[i] - 1 && pk >= 0) begin
        model_take(i, pk);
        m[i].pre = 1'b1;
      end else if (mh[i] != 0 && m[i].hold < mh[i] - 1) begin
        m[i].hold++;
      end
    end
  endtask

  // One clock: advance the model, queue its predictions, then compare after the edge.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      e.inst = i;
      e.g    = m[i].v ? (8'h01 << m[i].own) : 8'h00;
      e.s    = m[i].own;
      e.v    = m[i].v;
      e.p    = m[i].pre;
      e.hold = m[i].hold;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      logic [31:0] got_hold;
      e = sb.pop_front();
      check($sformatf("sb%0d_grant", e.inst), 32'(g[e.inst]), 32'(e.g));
      check($sformatf("sb%0d_sel", e.inst), 32'(s[e.inst]), 32'(e.s));
      check($sformatf("sb%0d_valid", e.inst), 32'(v[e.inst]), 32'(e.v));
      check($sformatf("sb%0d_preempt", e.inst), 32'(p[e.inst]), 32'(e.p));
      if (e.inst != 2) begin
        got_hold = (e.inst == 0) ? 32'(u0.hold_cnt) : 32'(u4.hold_cnt);
        check($sformatf("sb%0d_hold", e.inst), got_hold, 32'(e.hold));
      end
    end
  endtask

  task automatic set_all(input logic [7:0] val);
    for (int i = 0; i < 3; i++) r[i] = val;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_grant%0d", tag, i), 32'(g[i]), 32'h0);
      check($sformatf("%s_sel%0d", tag, i), 32'(s[i]), 32'h0);
      check($sformatf("%s_valid%0d", tag, i), 32'(v[i]), 32'h0);
      check($sformatf("%s_preempt%0d", tag, i), 32'(p[i]), 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    set_all(8'h00);
    model_reset();
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full request set, each owner releases right after being granted: 0..7 then wrap to 0.
    set_all(8'hFF);
    cycle();
    for (int k = 0; k < 8; k++) begin
      check("t2_order", 32'(g[0]), 32'(8'h01 << k));
      check("t2_sel", 32'(s[0]), 32'(k));
      for (int i = 0; i < 3; i++) begin
        r[i] = r[i] & ~(8'h01 << k);
        if (k == 6) r[i] = r[i] | 8'h01;
      end
      cycle();
    end
    check("t2_wrap", 32'(g[0]), 32'h01);
    set_all(8'h00);
    cycle();

    // Owner 7 releases with 0 and 6 waiting: 0 first (wrap), then 6.
    set_all(8'h80);
    cycle();
    set_all(8'hC1);
    cycle();
    set_all(8'h41);
    cycle();
    check("t5_wrap0", 32'(g[0]), 32'h01);
    set_all(8'h40);
    cycle();
    check("t5_then6", 32'(g[0]), 32'h40);
    set_all(8'h00);
    cycle();

    // MAX_HOLD=4: owner 2 keeps the mux four cycles, then 5 preempts.
    set_all(8'h04);
    cycle();
    set_all(8'h24);
    for (int j = 0; j < 4; j++) begin
      check("t3_hold_grant", 32'(g[1]), 32'h04);
      check("t3_no_preempt", 32'(p[1]), 32'h0);
      cycle();
    end
    check("t3_preempt_grant", 32'(g[1]), 32'h20);
    check("t3_preempt_pulse", 32'(p[1]), 32'h1);
    cycle();
    check("t3_pulse_end", 32'(p[1]), 32'h0);
    check("t3_owner5", 32'(g[1]), 32'h20);
    set_all(8'h04);
    cycle();
    check("t3_back_to2", 32'(g[1]), 32'h04);
    set_all(8'h00);
    cycle();

    // MAX_HOLD=4 with a lone requester: no preemption, counter parks at 3.
    set_all(8'h40);
    for (int j = 0; j < 20; j++) begin
      cycle();
      check("t4_grant", 32'(g[1]), 32'h40);
      check("t4_no_preempt", 32'(p[1]), 32'h0);
    end
    check("t4_hold_sat", 32'(u4.hold_cnt), 32'd3);
    set_all(8'h00);
    cycle();

    // MAX_HOLD=0: owner 1 is never preempted; 4 takes over one cycle after release.
    set_all(8'h02);
    cycle();
    set_all(8'h12);
    for (int j = 0; j < 100; j++) begin
      cycle();
      check("t6_grant", 32'(g[2]), 32'h02);
      check("t6_no_preempt", 32'(p[2]), 32'h0);
    end
    set_all(8'h10);
    cycle();
    check("t6_handover", 32'(g[2]), 32'h10);
    set_all(8'h00);
    cycle();

    // Random request traffic with mostly-sticky bits.
    for (int j = 0; j < 200; j++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    // Asynchronous reset in the middle of a grant to owner 3.
    set_all(8'h08);
    cycle();
    cycle();
    check("t1_owner3", 32'(g[0]), 32'h08);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("t1_async");
    model_reset();
    set_all(8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    set_all(8'h01);
    cycle();
    check("t1_after_reset", 32'(g[0]), 32'h01);
    set_all(8'h00);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
